// File: rtl/cmd_sched_if.sv
// Command-bus bundle between the round-robin scheduler and its sources/decoders.
interface cmd_sched_if #(
  parameter int N_SRC = 4
) ();
  logic [N_SRC-1:0]         src_valid;
  logic [N_SRC-1:0][31:0]   src_cmd;
  logic [N_SRC-1:0]         src_ack;
  logic [N_SRC-1:0]         src_err;
  logic [31:0]              cmd;
  logic                     dec_done;
  logic [$clog2(N_SRC)-1:0] grant;
  logic                     sched_busy;

  modport master (
    input  src_valid, src_cmd, dec_done,
    output src_ack, src_err, cmd, grant, sched_busy
  );

  modport slave (
    output src_valid, src_cmd, dec_done,
    input  src_ack, src_err, cmd, grant, sched_busy
  );
endinterface

// File: rtl/cmd_sched.sv
// Round-robin owner of the shared 32-bit command bus: present one command, wait for the
// decoders' done (or time out), then hold the null command for a gap before re-arbitrating.
module cmd_sched #(
  parameter int N_SRC      = 4,
  parameter int TIMEOUT    = 1023,
  parameter int GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  cmd_sched_if.master bus
);
  localparam int GW  = $clog2(N_SRC);
  localparam int CW  = $clog2(TIMEOUT + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  logic [1:0]       state;
  logic [GW-1:0]    last, grant_q, win, cand;
  logic             found;
  logic [CW-1:0]    cnt;
  logic [GCW-1:0]   gcnt;
  logic [31:0]      cmd_q;
  logic [N_SRC-1:0] ack_q, err_q;
  logic             busy_q;

  // Search starts one past the previous winner so every pending source is served in turn.
  always_comb begin
    found = 1'b0;
    win   = last;
    cand  = last;
    for (int i = 0; i < N_SRC; i++) begin
      cand = (cand == GW'(N_SRC - 1)) ? '0 : cand + GW'(1);
      if (!found && bus.src_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      last    <= GW'(N_SRC - 1);
      grant_q <= '0;
      cmd_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            last    <= win;
            grant_q <= win;
            busy_q  <= 1'b1;
            gcnt    <= '0;
            // A null-target command would never be answered; reject it without issuing.
            if (bus.src_cmd[win][31:24] == 8'h00) begin
              ack_q <= ONE << win;
              err_q <= ONE << win;
              state <= S_GAP;
            end else begin
              cmd_q <= bus.src_cmd[win];
              cnt   <= '0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.dec_done) begin
            cmd_q <= '0;
            ack_q <= ONE << grant_q;
            gcnt  <= '0;
            state <= S_GAP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            cmd_q <= '0;
            ack_q <= ONE << grant_q;
            err_q <= ONE << grant_q;
            gcnt  <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (gcnt == GCW'(GAP_CYCLES - 1)) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else begin
            gcnt <= gcnt + GCW'(1);
          end
        end
        default: begin
          state  <= S_IDLE;
          cmd_q  <= '0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd        = cmd_q;
  assign bus.src_ack    = ack_q;
  assign bus.src_err    = err_q;
  assign bus.grant      = grant_q;
  assign bus.sched_busy = busy_q;
endmodule

// File: tb/tb_cmd_sched.sv
// Bench for cmd_sched: directed vector table, reset/fairness sequences and random traffic,
// every cycle compared against a transaction-timing reference model.
module tb_cmd_sched;
  localparam int N   = 4;
  localparam int TO  = 1023;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmd_sched_if #(.N_SRC(N)) bus ();
  cmd_sched #(.N_SRC(N), .TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the issued transaction by edge timestamps.
  int          n_edge = 0;
  bit          m_pres = 0;
  int          m_start = 0, m_gap_end = 0, m_last = N - 1, m_grant = 0;
  logic [31:0] m_cmd = '0;
  logic [N-1:0] m_ack = '0, m_err = '0;
  bit          m_busy = 0;

  task automatic model_edge();
    bit fnd;
    m_ack = '0;
    m_err = '0;
    if (rst) begin
      m_pres = 0; m_gap_end = n_edge + 1; m_last = N - 1; m_grant = 0; m_cmd = '0;
    end else if (m_pres) begin
      if (bus.dec_done) begin
        m_ack[m_grant] = 1'b1; m_pres = 0; m_gap_end = n_edge + GAP + 1;
      end else if (n_edge - m_start == TO) begin
        m_ack[m_grant] = 1'b1; m_err[m_grant] = 1'b1; m_pres = 0; m_gap_end = n_edge + GAP + 1;
      end
    end else if (n_edge >= m_gap_end && bus.src_valid != '0) begin
      fnd = 0;
      for (int k = 1; k <= N; k++) begin
        if (!fnd && bus.src_valid[(m_last + k) % N]) begin
          fnd = 1; m_grant = (m_last + k) % N;
        end
      end
      m_last = m_grant;
      if (bus.src_cmd[m_grant][31:24] == 8'h00) begin
        m_ack[m_grant] = 1'b1; m_err[m_grant] = 1'b1; m_gap_end = n_edge + GAP + 1;
      end else begin
        m_pres = 1; m_start = n_edge; m_cmd = bus.src_cmd[m_grant];
      end
    end
    m_busy = m_pres || (n_edge + 1 < m_gap_end);
  endtask

  task automatic step();
    logic [1:0] mg;
    @(posedge clk);
    model_edge();
    n_edge++;
    #1;
    mg = m_grant[1:0];
    chk("cycle_outputs",
        {21'b0, bus.cmd, bus.src_ack, bus.src_err, bus.grant, bus.sched_busy},
        {21'b0, (m_pres ? m_cmd : 32'h0), m_ack, m_err, mg, m_busy});
  endtask

  typedef struct {
    int          src;
    logic [31:0] c;
    int          d;        // cycles of presentation before dec_done, -1 = never
    int          exp_len;
    bit          exp_err;
  } vec_t;

  vec_t vt[5];

  initial begin
    int len, cyc, ng;
    bit got;
    logic [N-1:0] ack_v, err_v, drop;
    logic [31:0] prev_cmd;
    int grants[8];

    vt[0] = '{1, 32'h01020ABC, 5, 5, 1'b0};
    vt[1] = '{2, 32'h0A0B0C0D, -1, TO, 1'b1};
    vt[2] = '{3, 32'h7F000001, TO, TO, 1'b0};
    vt[3] = '{0, 32'h00051234, -1, 0, 1'b1};
    vt[4] = '{0, 32'hFF00FFFF, 1, 1, 1'b0};

    rst = 1'b1;
    bus.src_valid = '0;
    bus.src_cmd   = '0;
    bus.dec_done  = 1'b0;
    step();
    step();
    chk("reset_cmd",   bus.cmd, 0);
    chk("reset_ack",   bus.src_ack, 0);
    chk("reset_err",   bus.src_err, 0);
    chk("reset_grant", bus.grant, 0);
    chk("reset_busy",  bus.sched_busy, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      bus.src_valid[vt[i].src] = 1'b1;
      bus.src_cmd[vt[i].src]   = vt[i].c;
      len = 0; cyc = 0; got = 0; ack_v = '0; err_v = '0;
      while (!got && cyc < 3000) begin
        step();
        cyc++;
        if (bus.src_ack != '0) begin
          got = 1; ack_v = bus.src_ack; err_v = bus.src_err; bus.src_valid = '0;
        end else if (bus.cmd == vt[i].c) begin
          len++;
        end
        bus.dec_done = (bus.cmd != 0 && len == vt[i].d);
      end
      chk("vec_ack", ack_v, 64'(1) << vt[i].src);
      chk("vec_err", err_v, 64'(vt[i].exp_err) << vt[i].src);
      chk("vec_len", len, vt[i].exp_len);
      repeat (GAP) step();
      chk("vec_gap_cmd",  bus.cmd, 0);
      chk("vec_idle_busy", bus.sched_busy, 0);
    end

    // Reset in the middle of a presented command: no ack, pointer restarts at source 0.
    bus.src_valid[2] = 1'b1;
    bus.src_cmd[2]   = 32'h05060708;
    cyc = 0;
    while (bus.cmd == 0 && cyc < 20) begin step(); cyc++; end
    chk("mid_rst_issued", bus.cmd, 32'h05060708);
    repeat (3) step();
    rst = 1'b1;
    bus.src_valid = '0;
    step();
    chk("mid_rst_cmd",  bus.cmd, 0);
    chk("mid_rst_ack",  bus.src_ack, 0);
    chk("mid_rst_busy", bus.sched_busy, 0);
    rst = 1'b0;

    // Fairness: every source keeps re-requesting; grants must rotate from 0.
    for (int s = 0; s < N; s++) bus.src_cmd[s] = {8'h10 + 8'(s), 8'hA0, 16'(s)};
    ng = 0; len = 0; cyc = 0; drop = '0; prev_cmd = '0;
    while ((ng < 5 || bus.sched_busy) && cyc < 400) begin
      bus.src_valid = (ng < 5) ? ~drop : '0;
      step();
      cyc++;
      drop = bus.src_ack;
      if (bus.src_ack != '0) len = 0;
      else if (bus.cmd != 0) len++;
      if (bus.cmd != 0 && prev_cmd == 0 && ng < 8) begin grants[ng] = bus.grant; ng++; end
      prev_cmd = bus.cmd;
      bus.dec_done = (bus.cmd != 0 && len == 3);
    end
    chk("rr_count", ng, 5);
    for (int k = 0; k < 5; k++) chk("rr_grant", grants[k], k % N);
    bus.src_valid = '0;
    bus.dec_done  = 1'b0;

    // Random traffic: null targets, late src_cmd changes, valid dropped mid-command.
    for (int c = 0; c < 4000; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!bus.src_valid[s] && $urandom_range(3) == 0) begin
          bus.src_valid[s] = 1'b1;
          bus.src_cmd[s] = {($urandom_range(7) == 0) ? 8'h00 : 8'($urandom_range(255, 1)), 24'($urandom)};
        end
      end
      if ($urandom_range(49) == 0) bus.src_cmd[$urandom_range(N - 1)] = $urandom;
      if (m_pres && $urandom_range(40) == 0) bus.src_valid[m_grant] = 1'b0;
      bus.dec_done = ($urandom_range(5) == 0);
      step();
      bus.src_valid &= ~bus.src_ack;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
